iot_event_scanner: RTL and testbench
====================================

# iot_event_scanner

Upstream front end for the active-IoT-device monitor. It takes one raw activity line per device, synchronises and debounces each line, and records connect/disconnect edges as pending events. It then issues them one per cycle, round-robin, as a single-cycle `change` pulse with an `on_off` direction. The `change`/`on_off` pair wires directly to the monitor counter's inputs.

## Interface
- `N_DEV`, default 8: number of device lines. Range 2–32.
- `DEB_CYCLES`, default 4: consecutive cycles a synchronised line must differ from its debounced state before the state flips. Must be ≥ 2.
- `ID_W`, default `$clog2(N_DEV)`: width of `dev_id`.

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `dev_active`  in  N_DEV  raw per-device activity, asynchronous to `clk`
- `scan_en`  in  1  1 = grants allowed; 0 = hold all pending events
- `change`  out  1  one-cycle pulse: one device event issued
- `on_off`  out  1  direction of issued event, valid when `change`=1: 1 = connect, 0 = disconnect
- `dev_id`  out  ID_W  index of device whose event is issued, valid when `change`=1
- `pending`  out  N_DEV  registered pending-event flags
- `cancel_cnt`  out  8  saturating count of cancelled (net-zero) event pairs

## Operation
**Reset** (`rst`=0, asynchronous):
- `change`, `on_off`, `dev_id`, `pending`, `cancel_cnt` all go to 0.
- Sync flops, debounced states and debounce counters go to 0; all devices are treated as inactive.
- Round-robin pointer goes to 0.

**Synchroniser.** Each `dev_active` bit passes through a 2-flop synchroniser giving `s2[i]`.

**Debounce**, per device, with counter `cnt[i]` of width `$clog2(DEB_CYCLES)`:
- If `s2[i]` equals `deb[i]`: `cnt[i]` is set to 0.
- Else if `cnt[i]` equals `DEB_CYCLES-1`: `deb[i]` is inverted, `cnt[i]` is set to 0, and a debounced edge is raised.
- Else: `cnt[i]` is incremented.
- A glitch shorter than `DEB_CYCLES` cycles produces no edge.

**Event record**, per device. Each device holds at most one pending event: flag `pending[i]` plus direction `dir[i]`.
- Debounced edge with `pending[i]`=0: set `pending[i]`=1 and `dir[i]` = new `deb[i]`.
- Debounced edge with `pending[i]`=1 and device not granted this cycle: the edge is necessarily opposite, so the pair cancels. Clear `pending[i]` and increment `cancel_cnt`, saturating at 255.
- Debounced edge in the same cycle the device is granted: the granted event is issued, and `pending[i]` stays 1 with `dir[i]` = new direction. No cancel.

**Arbiter:**
- When `scan_en`=1 and any `pending` bit is set, grant the first set index at or after `ptr`, searching cyclically upward.
- On the next edge: register `change`=1, `on_off`=`dir[g]`, `dev_id`=`g`; clear `pending[g]` (subject to the new-edge rule above); set `ptr` to `(g+1) mod N_DEV`.
- With no grant: `change`=0, and `on_off` and `dev_id` hold their previous values.
- At most one event is issued per cycle. `scan_en`=0 blocks grants but does not affect debounce or cancellation.

## Timing
- Raw edge sampled at clock edge 0 → `s2` updates at edge 1 → `deb` flips and `pending` is set at edge 1+DEB_CYCLES → `change` is registered at edge 2+DEB_CYCLES when uncontended. With DEB_CYCLES=4 this is edge 6.
- Under contention, a device waits at most N_DEV−1 additional cycles, because fairness is round-robin.
- `change` is never high on two consecutive cycles for the same `dev_id` unless a new debounced edge intervened.
- Reset asserted mid-operation discards all pending events immediately, and `change` drops without waiting for a clock edge. After release, the first event can appear no earlier than edge 2+DEB_CYCLES.
- A `dev_active` line already high at reset release is reported as a connect after the normal latency.

## Test plan
- Reset release with `dev_active`=0x00, then set bit 3 high and hold → exactly one `change`=1, `on_off`=1, `dev_id`=3, at edge 6 after the input change (DEB_CYCLES=4). `pending` returns to 0x00.
- Bit 5 pulses high for 3 cycles (< DEB_CYCLES) → no `change`, `pending` stays 0, `cancel_cnt`=0.
- `scan_en`=0; `dev_active` goes 0x00→0xFF; wait 10 cycles; then `scan_en`=1 → `pending`=0xFF, followed by 8 consecutive `change` pulses with `dev_id` 0,1,…,7, all with `on_off`=1.
- `scan_en`=0; bit 2 rises, is debounced, then falls and is debounced again → `pending[2]` is set then cleared, `cancel_cnt`=1, and no `change` occurs after `scan_en`=1.
- `scan_en`=1 with devices 6, 1 and 7 all pending and `ptr`=6 → grant order 6, 7, 1. Then bring 0 pending → 0 is granted next.
- Drive `rst`=0 asynchronously between clock edges while `pending`≠0 → all outputs read 0 before the next clock edge, and no stale event is emitted after release.

Source files
------------

// File: rtl/iot_event_scanner.sv
// Per-device synchroniser + debouncer feeding a one-deep event record per line,
// drained one event per cycle by a round-robin arbiter into a change/on_off pulse.
module iot_event_scanner #(
  parameter int N_DEV      = 8,
  parameter int DEB_CYCLES = 4,
  parameter int ID_W       = $clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_active,
  input  logic             scan_en,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic [N_DEV-1:0] pending,
  output logic [7:0]       cancel_cnt
);

  localparam int              CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [ID_W:0]    N_DEV_W = (ID_W + 1)'(N_DEV);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_DEV - 1);
  localparam int              CAN_W   = $clog2(N_DEV + 1);

  logic [N_DEV-1:0] r_s1;
  logic [N_DEV-1:0] r_s2;
  logic [N_DEV-1:0] r_deb;
  logic [CNT_W-1:0] r_cnt [N_DEV];
  logic [N_DEV-1:0] r_pending;
  logic [N_DEV-1:0] r_dir;
  logic [ID_W-1:0]  r_ptr;
  logic             r_change;
  logic             r_on_off;
  logic [ID_W-1:0]  r_dev_id;
  logic [7:0]       r_cancel_cnt;

  logic [N_DEV-1:0] w_edge;
  logic [N_DEV-1:0] w_gnt_oh;
  logic [N_DEV-1:0] w_cancel;
  logic             w_grant_vld;
  logic [ID_W-1:0]  w_grant_idx;
  logic [ID_W:0]    w_scan;
  logic [CAN_W-1:0] w_cancel_n;
  logic [8:0]       w_cnt_sum;
  logic [7:0]       w_cancel_cnt_next;

  // A debounced edge fires on the cycle the counter would run past its limit.
  genvar gi;
  generate
    for (gi = 0; gi < N_DEV; gi++) begin : g_dev
      assign w_edge[gi]   = (r_s2[gi] != r_deb[gi]) && (r_cnt[gi] == CNT_MAX);
      assign w_gnt_oh[gi] = w_grant_vld && (w_grant_idx == ID_W'(gi));
      assign w_cancel[gi] = w_edge[gi] && r_pending[gi] && !w_gnt_oh[gi];
    end
  endgenerate

  // Cyclic first-set search starting at the round-robin pointer.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 0; k < N_DEV; k++) begin
      w_scan = {1'b0, r_ptr} + (ID_W + 1)'(k);
      if (w_scan >= N_DEV_W) begin
        w_scan = w_scan - N_DEV_W;
      end
      if (scan_en && !w_grant_vld && r_pending[w_scan[ID_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_scan[ID_W-1:0];
      end
    end
  end

  // Several lines may cancel in the same cycle; each pair counts once.
  always_comb begin
    w_cancel_n = '0;
    for (int k = 0; k < N_DEV; k++) begin
      w_cancel_n = w_cancel_n + CAN_W'(w_cancel[k]);
    end
    w_cnt_sum         = {1'b0, r_cancel_cnt} + 9'(w_cancel_n);
    w_cancel_cnt_next = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_deb        <= '0;
      r_pending    <= '0;
      r_dir        <= '0;
      r_ptr        <= '0;
      r_change     <= 1'b0;
      r_on_off     <= 1'b0;
      r_dev_id     <= '0;
      r_cancel_cnt <= '0;
      for (int k = 0; k < N_DEV; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_s1 <= dev_active;
      r_s2 <= r_s1;

      for (int k = 0; k < N_DEV; k++) begin
        if (r_s2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_MAX) begin
          r_deb[k] <= ~r_deb[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end

        // A new edge re-arms the record if it was empty or is being issued now;
        // otherwise it is the opposite of the unissued event and both vanish.
        if (w_edge[k]) begin
          if (!r_pending[k] || w_gnt_oh[k]) begin
            r_pending[k] <= 1'b1;
            r_dir[k]     <= ~r_deb[k];
          end else begin
            r_pending[k] <= 1'b0;
          end
        end else if (w_gnt_oh[k]) begin
          r_pending[k] <= 1'b0;
        end
      end

      r_cancel_cnt <= w_cancel_cnt_next;

      if (w_grant_vld) begin
        r_change <= 1'b1;
        r_on_off <= r_dir[w_grant_idx];
        r_dev_id <= w_grant_idx;
        r_ptr    <= (w_grant_idx == LAST_ID) ? '0 : w_grant_idx + ID_W'(1);
      end else begin
        r_change <= 1'b0;
      end
    end
  end

  assign change     = r_change;
  assign on_off     = r_on_off;
  assign dev_id     = r_dev_id;
  assign pending    = r_pending;
  assign cancel_cnt = r_cancel_cnt;

endmodule

// File: tb/tb_iot_event_scanner.sv
// Directed bench for iot_event_scanner (N_DEV=8, DEB_CYCLES=4): a per-cycle vector
// table for the basic connect/glitch/disconnect flow plus hand-written corner sequences.
module tb_iot_event_scanner;

  logic       clk;
  logic       rst_n;
  logic [7:0] dev_active;
  logic       scan_en;
  logic       change;
  logic       on_off;
  logic [2:0] dev_id;
  logic [7:0] pending;
  logic [7:0] cancel_cnt;

  int n_pass  = 0;
  int n_total = 0;

  iot_event_scanner #(
    .N_DEV     (8),
    .DEB_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .dev_active(dev_active),
    .scan_en   (scan_en),
    .change    (change),
    .on_off    (on_off),
    .dev_id    (dev_id),
    .pending   (pending),
    .cancel_cnt(cancel_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] act;
    logic       en;
    logic       chg;
    logic       oo;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] cc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [7:0] act, input logic en, input logic chg, input logic oo,
                     input logic [2:0] id, input logic [7:0] pend, input logic [7:0] cc);
    vec_t v;
    v.act = act; v.en = en; v.chg = chg; v.oo = oo; v.id = id; v.pend = pend; v.cc = cc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_event(input string name, input logic [2:0] id, input logic oo);
    chk({name, ".change"}, 32'(change), 32'd1);
    chk({name, ".dev_id"}, 32'(dev_id), 32'(id));
    chk({name, ".on_off"}, 32'(on_off), 32'(oo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector entry k is the state after clock edge k following the input change.
    for (int k = 0; k < 5; k++) add(8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'd0);
    add(8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08, 8'd0);
    add(8'h08, 1'b1, 1'b1, 1'b1, 3'd3, 8'h00, 8'd0);
    add(8'h08, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 8'd0);
    for (int k = 0; k < 3; k++) add(8'h28, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 8'd0);
    for (int k = 0; k < 6; k++) add(8'h08, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 8'd0);
    for (int k = 0; k < 5; k++) add(8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 8'd0);
    add(8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 8'd0);
    add(8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 8'd0);
    add(8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 8'd0);

    rst_n      = 1'b0;
    dev_active = 8'h00;
    scan_en    = 1'b1;
    #12;
    chk("reset.change", 32'(change), 32'd0);
    chk("reset.on_off", 32'(on_off), 32'd0);
    chk("reset.dev_id", 32'(dev_id), 32'd0);
    chk("reset.pending", 32'(pending), 32'd0);
    chk("reset.cancel_cnt", 32'(cancel_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);

    // Connect on bit 3, 3-cycle glitch on bit 5, then disconnect on bit 3.
    for (int i = 0; i < vq.size(); i++) begin
      dev_active = vq[i].act;
      scan_en    = vq[i].en;
      tick(1);
      chk($sformatf("vec%0d.change", i), 32'(change), 32'(vq[i].chg));
      chk($sformatf("vec%0d.on_off", i), 32'(on_off), 32'(vq[i].oo));
      chk($sformatf("vec%0d.dev_id", i), 32'(dev_id), 32'(vq[i].id));
      chk($sformatf("vec%0d.pending", i), 32'(pending), 32'(vq[i].pend));
      chk($sformatf("vec%0d.cancel_cnt", i), 32'(cancel_cnt), 32'(vq[i].cc));
    end

    // Fresh reset so the round-robin pointer starts at 0.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Bit 2 rises and falls while grants are held: the pair cancels.
    scan_en    = 1'b0;
    dev_active = 8'h04;
    tick(7);
    chk("cancel.pending_set", 32'(pending), 32'h04);
    chk("cancel.no_change", 32'(change), 32'd0);
    dev_active = 8'h00;
    tick(7);
    chk("cancel.pending_clr", 32'(pending), 32'h00);
    chk("cancel.cancel_cnt", 32'(cancel_cnt), 32'd1);
    scan_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk($sformatf("cancel.idle%0d.change", k), 32'(change), 32'd0);
    end

    // All lines connect while held, then drain in index order.
    scan_en    = 1'b0;
    dev_active = 8'hFF;
    tick(10);
    chk("all.pending", 32'(pending), 32'hFF);
    chk("all.held_change", 32'(change), 32'd0);
    scan_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk_event($sformatf("all.grant%0d", k), 3'(k), 1'b1);
    end
    tick(1);
    chk("all.done_change", 32'(change), 32'd0);
    chk("all.done_pending", 32'(pending), 32'h00);

    // Issue device 5 to move the pointer to 6, then contend 6, 1, 7.
    dev_active = 8'hDF;
    tick(7);
    chk_event("rr.dev5", 3'd5, 1'b0);
    scan_en    = 1'b0;
    dev_active = 8'h1D;
    tick(7);
    chk("rr.pending", 32'(pending), 32'hC2);
    scan_en = 1'b1;
    tick(1);
    chk_event("rr.first", 3'd6, 1'b0);
    tick(1);
    chk_event("rr.second", 3'd7, 1'b0);
    tick(1);
    chk_event("rr.third", 3'd1, 1'b0);
    dev_active = 8'h1C;
    tick(7);
    chk_event("rr.wrap0", 3'd0, 1'b0);

    // Asynchronous reset with events in flight, bit 2 high across release.
    scan_en    = 1'b0;
    dev_active = 8'h04;
    tick(7);
    chk("arst.pending_pre", 32'(pending), 32'h18);
    scan_en = 1'b1;
    tick(1);
    chk_event("arst.live", 3'd3, 1'b0);
    chk("arst.pending_live", 32'(pending), 32'h10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.change", 32'(change), 32'd0);
    chk("arst.on_off", 32'(on_off), 32'd0);
    chk("arst.dev_id", 32'(dev_id), 32'd0);
    chk("arst.pending", 32'(pending), 32'd0);
    chk("arst.cancel_cnt", 32'(cancel_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk($sformatf("arst.edge%0d.change", k), 32'(change), 32'd0);
    end
    chk("arst.pending_new", 32'(pending), 32'h04);
    tick(1);
    chk_event("arst.connect", 3'd2, 1'b1);
    tick(1);
    chk("arst.after_change", 32'(change), 32'd0);
    chk("arst.after_pending", 32'(pending), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
